prog_address_decoder: RTL and testbench

- Parametrised, programmable successor to the fixed 68K address decoder.
- Holds NUM_REGIONS base/mask/enable windows, writable at run time, and decodes the 68K address on each bus cycle.
- Latches a one-hot chip select for the whole cycle (AS_L low).
- Runs a DTACK watchdog that asserts bus error for unmapped or unanswered accesses.
- Sits between the CPU bus and the ROM/RAM/DRAM/IO/CAN slave selects.

---
 rtl/prog_address_decoder.sv | 163 ++++++++++++++++
 tb/tb_prog_address_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_address_decoder.sv
// Programmable 68K address decoder: run-time base/mask/enable windows, a one-hot
// chip select latched for the whole bus cycle, and a DTACK watchdog.
module prog_address_decoder #(
    parameter int                ADDR_W      = 32,
    parameter int                NUM_REGIONS = 8,
    parameter int                IDX_W       = 4,
    parameter int                TIMEOUT     = 255,
    parameter logic [ADDR_W-1:0] R0_BASE     = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] R0_MASK     = ADDR_W'(32'hFFFF_8000)
) (
    input  logic                   Clk,
    input  logic                   Reset_H,
    input  logic [ADDR_W-1:0]      Address,
    input  logic                   AS_L,
    input  logic                   DtackIn_L,
    input  logic                   CfgWe_H,
    input  logic [IDX_W-1:0]       CfgIdx,
    input  logic [1:0]             CfgField,
    input  logic [ADDR_W-1:0]      CfgData,
    output logic [NUM_REGIONS-1:0] Select_H,
    output logic                   Unmapped_H,
    output logic                   BusError_L,
    output logic                   Busy_H
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERROR  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [NUM_REGIONS-1:0]   sel_q, sel_d;
    logic                     unmapped_q, unmapped_d;
    logic                     bus_err_l_q, bus_err_l_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;

    logic [ADDR_W-1:0]        base_q [NUM_REGIONS];
    logic [ADDR_W-1:0]        base_d [NUM_REGIONS];
    logic [ADDR_W-1:0]        mask_q [NUM_REGIONS];
    logic [ADDR_W-1:0]        mask_d [NUM_REGIONS];
    logic [NUM_REGIONS-1:0]   en_q, en_d;

    logic                     hit;
    logic [NUM_REGIONS-1:0]   win;

    // Scan from the top so the lowest matching index is the last to overwrite win.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (en_q[i] && ((Address & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
                hit    = 1'b1;
                win    = '0;
                win[i] = 1'b1;
            end
        end
    end

    // Indices beyond the table simply never compare equal, so they are dropped.
    always_comb begin
        base_d = base_q;
        mask_d = mask_q;
        en_d   = en_q;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (CfgWe_H && (32'(CfgIdx) == 32'(i))) begin
                case (CfgField)
                    2'd0:    base_d[i] = CfgData;
                    2'd1:    mask_d[i] = CfgData;
                    2'd2:    en_d[i]   = CfgData[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        unmapped_d  = unmapped_q;
        bus_err_l_d = bus_err_l_q;
        tmr_d       = tmr_q;
        case (state_q)
            S_IDLE: begin
                sel_d       = '0;
                unmapped_d  = 1'b0;
                bus_err_l_d = 1'b1;
                tmr_d       = '0;
                if (!AS_L) begin
                    if (hit) begin
                        state_d = S_ACTIVE;
                        sel_d   = win;
                    end else begin
                        state_d     = S_ERROR;
                        unmapped_d  = 1'b1;
                        bus_err_l_d = 1'b0;
                    end
                end
            end
            S_ACTIVE: begin
                // End of bus cycle wins over a timeout landing on the same edge.
                if (AS_L) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    tmr_d   = '0;
                end else if (DtackIn_L) begin
                    if (tmr_q == TMR_LAST) begin
                        state_d     = S_ERROR;
                        bus_err_l_d = 1'b0;
                    end else if (tmr_q != TMR_MAX) begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_ERROR: begin
                if (AS_L) begin
                    state_d     = S_IDLE;
                    sel_d       = '0;
                    unmapped_d  = 1'b0;
                    bus_err_l_d = 1'b1;
                    tmr_d       = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            unmapped_q  <= 1'b0;
            bus_err_l_q <= 1'b1;
            tmr_q       <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= (i == 0) ? R0_BASE : '0;
                mask_q[i] <= (i == 0) ? R0_MASK : '0;
                en_q[i]   <= (i == 0);
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            unmapped_q  <= unmapped_d;
            bus_err_l_q <= bus_err_l_d;
            tmr_q       <= tmr_d;
            base_q      <= base_d;
            mask_q      <= mask_d;
            en_q        <= en_d;
        end
    end

    assign Select_H   = sel_q;
    assign Unmapped_H = unmapped_q;
    assign BusError_L = bus_err_l_q;
    assign Busy_H     = (state_q != S_IDLE);

endmodule

// File: tb/tb_prog_address_decoder.sv
// Bench for prog_address_decoder: a vector table for the decode/config paths and
// hand-written sequences for the timeout and mid-cycle reset cases.
module tb_prog_address_decoder;

    logic        clk = 1'b0;
    logic        reset_h = 1'b1;
    logic [31:0] address = '0;
    logic        as_l = 1'b1;
    logic        dtack_l = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [1:0]  cfg_field = '0;
    logic [31:0] cfg_data = '0;
    logic [7:0]  select_h;
    logic        unmapped_h;
    logic        bus_error_l;
    logic        busy_h;

    int checks = 0;
    int errors = 0;

    // Expected output word: {Select_H, Unmapped_H, BusError_L, Busy_H}
    logic [10:0] exp_q[$];
    string       tag_q[$];

    localparam logic [10:0] IDL = {8'h00, 1'b0, 1'b1, 1'b0};
    localparam logic [10:0] UNM = {8'h00, 1'b1, 1'b0, 1'b1};

    typedef struct {
        logic        rst;
        logic        as_l;
        logic [31:0] addr;
        logic        dtack_l;
        logic        we;
        logic [3:0]  idx;
        logic [1:0]  field;
        logic [31:0] data;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    prog_address_decoder dut (
        .Clk        (clk),
        .Reset_H    (reset_h),
        .Address    (address),
        .AS_L       (as_l),
        .DtackIn_L  (dtack_l),
        .CfgWe_H    (cfg_we),
        .CfgIdx     (cfg_idx),
        .CfgField   (cfg_field),
        .CfgData    (cfg_data),
        .Select_H   (select_h),
        .Unmapped_H (unmapped_h),
        .BusError_L (bus_error_l),
        .Busy_H     (busy_h)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] sel_ex(input logic [7:0] s);
        return {s, 1'b0, 1'b1, 1'b1};
    endfunction

    function automatic vec_t bus(input logic a, input logic [31:0] ad, input logic d, input logic [10:0] e);
        vec_t v;
        v = '{rst: 1'b0, as_l: a, addr: ad, dtack_l: d, we: 1'b0, idx: 4'd0, field: 2'd0, data: 32'd0, exp: e};
        return v;
    endfunction

    function automatic vec_t cfg(input logic [3:0] ix, input logic [1:0] f, input logic [31:0] dt);
        vec_t v;
        v = '{rst: 1'b0, as_l: 1'b1, addr: 32'd0, dtack_l: 1'b1, we: 1'b1, idx: ix, field: f, data: dt, exp: IDL};
        return v;
    endfunction

    task automatic drive(input vec_t v, input string tag);
        @(negedge clk);
        reset_h   = v.rst;
        as_l      = v.as_l;
        address   = v.addr;
        dtack_l   = v.dtack_l;
        cfg_we    = v.we;
        cfg_idx   = v.idx;
        cfg_field = v.field;
        cfg_data  = v.data;
        exp_q.push_back(v.exp);
        tag_q.push_back(tag);
        @(posedge clk);
    endtask

    // Scoreboard: one expectation per driven cycle, checked just after the edge.
    always @(posedge clk) begin
        logic [10:0] got;
        logic [10:0] exp;
        string       tag;
        #1;
        if (exp_q.size() != 0) begin
            got = {select_h, unmapped_h, bus_error_l, busy_h};
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            if (got !== exp)
                begin
                    errors++;
                    $display("FAIL %s: got sel=%h unm=%b berr_l=%b busy=%b, want sel=%h unm=%b berr_l=%b busy=%b",
                             tag, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
                end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Reset and a basic region 0 access
        v = bus(1'b1, 32'h0, 1'b1, IDL); v.rst = 1'b1; tbl.push_back(v);
        tbl.push_back(bus(1'b1, 32'h0000_1234, 1'b1, IDL));
        tbl.push_back(bus(1'b0, 32'h0000_1234, 1'b1, sel_ex(8'h01)));
        tbl.push_back(bus(1'b0, 32'h0000_1234, 1'b1, sel_ex(8'h01)));
        tbl.push_back(bus(1'b0, 32'h0000_1234, 1'b0, sel_ex(8'h01)));
        tbl.push_back(bus(1'b1, 32'h0000_1234, 1'b1, IDL));
        // Region 3 window and an unmapped access just past it
        tbl.push_back(cfg(4'd3, 2'd0, 32'hF000_0000));
        tbl.push_back(cfg(4'd3, 2'd1, 32'hFFFC_0000));
        tbl.push_back(cfg(4'd3, 2'd2, 32'h1));
        tbl.push_back(bus(1'b0, 32'hF003_FFFC, 1'b0, sel_ex(8'h08)));
        tbl.push_back(bus(1'b1, 32'hF003_FFFC, 1'b1, IDL));
        tbl.push_back(bus(1'b0, 32'hF004_0000, 1'b1, UNM));
        tbl.push_back(bus(1'b0, 32'hF004_0000, 1'b1, UNM));
        tbl.push_back(bus(1'b1, 32'hF004_0000, 1'b1, IDL));
        // Overlapping regions 1 and 2
        tbl.push_back(cfg(4'd1, 2'd0, 32'h0800_0000));
        tbl.push_back(cfg(4'd1, 2'd1, 32'hF800_0000));
        tbl.push_back(cfg(4'd1, 2'd2, 32'h1));
        tbl.push_back(cfg(4'd2, 2'd0, 32'h0800_0000));
        tbl.push_back(cfg(4'd2, 2'd1, 32'hFF00_0000));
        tbl.push_back(cfg(4'd2, 2'd2, 32'h1));
        tbl.push_back(bus(1'b0, 32'h0800_0000, 1'b0, sel_ex(8'h02)));
        tbl.push_back(bus(1'b1, 32'h0800_0000, 1'b1, IDL));
        tbl.push_back(cfg(4'd1, 2'd2, 32'h0));
        tbl.push_back(bus(1'b0, 32'h0800_0000, 1'b0, sel_ex(8'h04)));
        tbl.push_back(bus(1'b1, 32'h0800_0000, 1'b1, IDL));
        // Mask rewrite during an active cycle only affects the next cycle
        tbl.push_back(bus(1'b0, 32'h0000_1234, 1'b1, sel_ex(8'h01)));
        v = bus(1'b0, 32'h0000_1234, 1'b1, sel_ex(8'h01));
        v.we = 1'b1; v.idx = 4'd0; v.field = 2'd1; v.data = 32'hFFFF_F000;
        tbl.push_back(v);
        tbl.push_back(bus(1'b1, 32'h0000_1234, 1'b1, IDL));
        tbl.push_back(bus(1'b0, 32'h0000_1234, 1'b1, UNM));
        tbl.push_back(bus(1'b1, 32'h0000_1234, 1'b1, IDL));
        // Out-of-range index and field 3 must leave the table untouched
        tbl.push_back(cfg(4'd9, 2'd2, 32'h1));
        tbl.push_back(cfg(4'd0, 2'd3, 32'h0));
        tbl.push_back(bus(1'b0, 32'h0800_0000, 1'b0, sel_ex(8'h04)));
        tbl.push_back(bus(1'b1, 32'h0800_0000, 1'b1, IDL));
        tbl.push_back(bus(1'b0, 32'h0000_0FFC, 1'b0, sel_ex(8'h01)));
        tbl.push_back(bus(1'b1, 32'h0000_0FFC, 1'b1, IDL));

        for (int i = 0; i < tbl.size(); i++)
            drive(tbl[i], $sformatf("vec%0d", i));

        // Timeout: error edge lands 255 edges after the select edge
        drive(bus(1'b0, 32'h0000_0100, 1'b1, sel_ex(8'h01)), "tmo_start");
        for (int i = 1; i < 255; i++)
            drive(bus(1'b0, 32'h0000_0100, 1'b1, sel_ex(8'h01)), $sformatf("tmo_wait%0d", i));
        drive(bus(1'b0, 32'h0000_0100, 1'b1, {8'h01, 1'b0, 1'b0, 1'b1}), "tmo_fire");
        drive(bus(1'b0, 32'h0000_0100, 1'b1, {8'h01, 1'b0, 1'b0, 1'b1}), "tmo_hold");
        drive(bus(1'b1, 32'h0000_0100, 1'b1, IDL), "tmo_release");

        // DTACK at cycle 10 freezes the timer, so no error follows
        drive(bus(1'b0, 32'h0000_0100, 1'b1, sel_ex(8'h01)), "dtk_start");
        for (int i = 1; i < 10; i++)
            drive(bus(1'b0, 32'h0000_0100, 1'b1, sel_ex(8'h01)), $sformatf("dtk_wait%0d", i));
        for (int i = 0; i < 300; i++)
            drive(bus(1'b0, 32'h0000_0100, 1'b0, sel_ex(8'h01)), $sformatf("dtk_frozen%0d", i));
        drive(bus(1'b1, 32'h0000_0100, 1'b1, IDL), "dtk_release");

        // Reset in the middle of a region 3 cycle also clears the table
        drive(bus(1'b0, 32'hF000_0000, 1'b1, sel_ex(8'h08)), "rst_active");
        v = bus(1'b0, 32'hF000_0000, 1'b1, IDL); v.rst = 1'b1;
        drive(v, "rst_pulse");
        drive(bus(1'b1, 32'hF000_0000, 1'b1, IDL), "rst_idle");
        drive(bus(1'b0, 32'hF000_0000, 1'b1, UNM), "rst_r3_gone");
        drive(bus(1'b1, 32'hF000_0000, 1'b1, IDL), "rst_r3_release");
        drive(bus(1'b0, 32'h0000_1234, 1'b1, sel_ex(8'h01)), "rst_r0_mask");
        drive(bus(1'b1, 32'h0000_1234, 1'b1, IDL), "rst_r0_release");

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
